// File: rtl/mdu_responder.sv
// Multiply/divide responder: runs mult/multu/div/divu over a fixed number of
// cycles and holds the HI/LO registers.
// busy is high for exactly MULT_CYCLES/DIV_CYCLES cycles after the start edge.
// Results land in HI/LO on the same edge that busy falls.
module mdu_responder #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q, busy_d;

  logic [63:0]   prod_s, prod_u;
  logic [31:0]   quo_s, rem_s, quo_u, rem_u;

  // Arithmetic on the latched operands; only consumed on the final RUN edge.
  // The divide-by-zero and INT_MIN/-1 cases are steered away from the
  // operators so no X or host overflow trap can leak into HI/LO.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    quo_s  = '0;
    rem_s  = '0;
    quo_u  = '0;
    rem_u  = '0;
    if (b_q != '0) begin
      quo_u = a_q / b_q;
      rem_u = a_q % b_q;
      if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
        quo_s = 32'h8000_0000;
        rem_s = '0;
      end else begin
        quo_s = $unsigned($signed(a_q) / $signed(b_q));
        rem_s = $unsigned($signed(a_q) % $signed(b_q));
      end
    end
  end

  // Next-state logic: accept requests in IDLE, count down in RUN, commit at 1->0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = CW'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = CW'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // start is deliberately ignored here; the pipeline stalls instead.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV:   if (b_q != '0) {hi_d, lo_d} = {rem_s, quo_s};
            OP_DIVU:  if (b_q != '0) {hi_d, lo_d} = {rem_u, quo_u};
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_responder.sv
// Bench for mdu_responder: directed vectors plus randomized op streams
// checked against an arithmetic model of HI/LO and the busy duration.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mdu_responder;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_hi, exp_lo;

  mdu_responder #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: HI/LO after an operation, from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint          ps, q, r;
    longint unsigned pu;
    case (mop)
      3'd0: begin
        ps = longint'($signed(ma)) * longint'($signed(mb));
        exp_hi = ps[63:32]; exp_lo = ps[31:0];
      end
      3'd1: begin
        pu = longint'({32'b0, ma}) * longint'({32'b0, mb});
        exp_hi = pu[63:32]; exp_lo = pu[31:0];
      end
      3'd2: if (mb != 0) begin
        q = longint'($signed(ma)) / longint'($signed(mb));
        r = longint'($signed(ma)) % longint'($signed(mb));
        exp_hi = r[31:0]; exp_lo = q[31:0];
      end
      3'd3: if (mb != 0) begin
        exp_hi = ma / mb; exp_lo = ma % mb;
        exp_lo = ma / mb; exp_hi = ma % mb;
      end
      3'd4: exp_hi = ma;
      3'd5: exp_lo = ma;
      default: ;
    endcase
  endtask

  // Issue one request and follow it to completion, checking busy duration,
  // HI/LO stability during the run and the final HI/LO values.
  task automatic run_op(input string name, input logic [2:0] rop, input logic [31:0] ra,
                        input logic [31:0] rb, input bit inject);
    logic [31:0] old_hi, old_lo;
    int k;
    int bcnt;
    old_hi = exp_hi; old_lo = exp_lo;
    model(rop, ra, rb);
    start = 1'b1; op = rop; a = ra; b = rb;
    step();
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    if (rop <= 3'd3) begin
      k = (rop <= 3'd1) ? MC : DC;
      bcnt = 0;
      while (busy === 1'b1 && bcnt < 100) begin
        vecs++;
        if (hi !== old_hi || lo !== old_lo) begin
          errs++;
          $display("FAIL %s hilo_during_run: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, old_hi, old_lo);
        end
        if (inject && bcnt == 2) begin
          start = 1'b1; op = 3'd5; a = 32'h99;
        end else begin
          start = 1'b0;
        end
        bcnt++;
        step();
      end
      start = 1'b0;
      vecs++;
      if (bcnt != k) begin
        errs++;
        $display("FAIL %s busy_cycles: got %0d required %0d", name, bcnt, k);
      end
    end
    vecs++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errs++;
      $display("FAIL %s result: busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h",
               name, busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_reset();
    start = 1'b0; op = '0; a = '0; b = '0;
    do_reset(2);
    vecs++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errs++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid_div();
    run_op("mthi_pre", 3'd4, 32'hDEAD_BEEF, 0, 0);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    step();
    start = 1'b0;
    step(); step();
    do_reset(2);
    vecs++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errs++;
      $display("FAIL reset_mid_div: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    repeat (DC + 2) begin
      step();
      vecs++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
        errs++;
        $display("FAIL reset_discard: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
      end
    end
    run_op("mult_after_reset", 3'd0, 32'd1234, 32'hFFFF_FFF0, 0);
  endtask

  task automatic test_mult();
    run_op("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    vecs++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errs++;
      $display("FAIL mult_const: hi=%h lo=%h required ffffffff/fffffffa", hi, lo);
    end
    repeat (4) run_op("mult_rand", 3'd0, $urandom, $urandom, 0);
  endtask

  task automatic test_multu();
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    vecs++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errs++;
      $display("FAIL multu_const: hi=%h lo=%h required fffffffe/00000001", hi, lo);
    end
    repeat (4) run_op("multu_rand", 3'd1, $urandom, $urandom, 0);
  endtask

  task automatic test_div();
    run_op("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    vecs++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errs++;
      $display("FAIL div_const: hi=%h lo=%h required ffffffff/fffffffd", hi, lo);
    end
    run_op("div_intmin", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    vecs++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      errs++;
      $display("FAIL div_intmin_const: hi=%h lo=%h required 00000000/80000000", hi, lo);
    end
    run_op("div_7_neg2", 3'd2, 32'd7, 32'hFFFF_FFFE, 0);
    repeat (4) run_op("div_rand", 3'd2, $urandom, 32'($urandom_range(1, 1000)) ^ {32{$urandom_range(0, 1) == 1}}, 0);
  endtask

  task automatic test_divu();
    run_op("divu_big", 3'd3, 32'hFFFF_FFFF, 32'd10, 0);
    repeat (4) run_op("divu_rand", 3'd3, $urandom, 32'($urandom_range(1, 70000)), 0);
  endtask

  task automatic test_mthi_mtlo();
    model(3'd4, 32'h1234_5678, 0);
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    step();
    vecs++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678) begin
      errs++;
      $display("FAIL mthi: busy=%b hi=%h required 0/12345678", busy, hi);
    end
    model(3'd5, 32'h9ABC_DEF0, 0);
    op = 3'd5; a = 32'h9ABC_DEF0;
    step();
    start = 1'b0;
    vecs++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      errs++;
      $display("FAIL mtlo: busy=%b hi=%h lo=%h required 0/12345678/9abcdef0", busy, hi, lo);
    end
  endtask

  task automatic test_div_by_zero();
    run_op("mthi_11", 3'd4, 32'h11, 0, 0);
    run_op("mtlo_22", 3'd5, 32'h22, 0, 0);
    run_op("divu_zero", 3'd3, 32'hCAFE, 32'h0, 1);
    vecs++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errs++;
      $display("FAIL divu_zero_keep: hi=%h lo=%h required 00000011/00000022", hi, lo);
    end
    run_op("div_zero", 3'd2, 32'h8000_0000, 32'h0, 0);
  endtask

  task automatic test_reserved();
    run_op("op6", 3'd6, $urandom, $urandom, 0);
    run_op("op7", 3'd7, $urandom, $urandom, 0);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  rop;
    logic [31:0] rb;
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      rb  = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom);
      run_op("rand_mix", rop, $urandom, rb, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    exp_hi = '0; exp_lo = '0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu();
    test_mthi_mtlo();
    test_div_by_zero();
    test_reserved();
    test_reset_mid_div();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
